controlador_valvula: RTL

//  Automatic level controller driving the valve block's abre_auto/fecha_auto command inputs.

---
 rtl/controlador_valvula_if.sv | 39 +++
 rtl/controlador_valvula.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/controlador_valvula_if.sv
// Signal bundle between the level sensor/operator side and the automatic valve controller.
// master drives enables and level samples; slave is the controller issuing valve commands.
interface controlador_valvula_if #(
  parameter int unsigned LARG_NIVEL = 8
);
  logic                  habilita;
  logic                  manual;
  logic [LARG_NIVEL-1:0] nivel;
  logic                  nivel_valido;
  logic                  abre_auto;
  logic                  fecha_auto;
  logic                  valvula_est;
  logic                  alarme;
  logic [2:0]            db_estado;

  modport master (
    output habilita,
    output manual,
    output nivel,
    output nivel_valido,
    input  abre_auto,
    input  fecha_auto,
    input  valvula_est,
    input  alarme,
    input  db_estado
  );

  modport slave (
    input  habilita,
    input  manual,
    input  nivel,
    input  nivel_valido,
    output abre_auto,
    output fecha_auto,
    output valvula_est,
    output alarme,
    output db_estado
  );
endinterface

// File: rtl/controlador_valvula.sv
// Automatic tank-level valve controller: hysteresis, minimum/maximum open time, sticky alarm.
// Optional consecutive-sample level filter enabled by defining CONTROLADOR_VALVULA_FILTRO_EN.
module controlador_valvula #(
  parameter int unsigned LARG_NIVEL   = 8,
  parameter int unsigned NIVEL_MIN    = 64,
  parameter int unsigned NIVEL_MAX    = 192,
  parameter int unsigned T_MIN_ABERTA = 1000,
  parameter int unsigned T_MAX_ABERTA = 100000,
  parameter int unsigned FILTRO_N     = 3
) (
  input logic                  clock,
  input logic                  reset,
  controlador_valvula_if.slave bus
);

  localparam int unsigned LARG_CONT = $clog2(T_MAX_ABERTA);

  localparam logic [LARG_NIVEL-1:0] LIM_BAIXO  = LARG_NIVEL'(NIVEL_MIN);
  localparam logic [LARG_NIVEL-1:0] LIM_ALTO   = LARG_NIVEL'(NIVEL_MAX);
  localparam logic [LARG_CONT-1:0]  CONT_TMIN  = LARG_CONT'(T_MIN_ABERTA - 1);
  localparam logic [LARG_CONT-1:0]  CONT_TMAX  = LARG_CONT'(T_MAX_ABERTA - 1);

  typedef enum logic [2:0] {
    StInicio  = 3'd0,
    StFechada = 3'd1,
    StAbre    = 3'd2,
    StAberta  = 3'd3,
    StFecha   = 3'd4,
    StAlarme  = 3'd5
  } estado_e;

  estado_e               estado_q, estado_d;
  logic [LARG_CONT-1:0]  cont_q, cont_d;
  logic                  alarme_q, alarme_d;

  // Raw level conditions, before optional filtering.
  logic amostra_baixa;
  logic amostra_alta;
  logic dispara_abre;
  logic dispara_fecha;

  assign amostra_baixa = bus.nivel_valido && bus.habilita && !bus.manual &&
                         (bus.nivel < LIM_BAIXO);
  assign amostra_alta  = bus.nivel_valido && (bus.nivel >= LIM_ALTO) && (cont_q >= CONT_TMIN);

`ifdef CONTROLADOR_VALVULA_FILTRO_EN
  localparam int unsigned LARG_FILTRO = $clog2(FILTRO_N + 1);
  localparam logic [LARG_FILTRO-1:0] FILTRO_ULT = LARG_FILTRO'(FILTRO_N - 1);

  logic [LARG_FILTRO-1:0] filtro_q, filtro_d;
  logic                   qualifica;

  always_comb begin
    qualifica = 1'b0;
    if (estado_q == StFechada) begin
      qualifica = amostra_baixa;
    end else if (estado_q == StAberta) begin
      qualifica = amostra_alta;
    end
  end

  // Fire on the FILTRO_N-th consecutive qualifying sample.
  assign dispara_abre  = amostra_baixa && (filtro_q == FILTRO_ULT);
  assign dispara_fecha = amostra_alta && (filtro_q == FILTRO_ULT);

  always_comb begin
    filtro_d = filtro_q;
    if (estado_d != estado_q) begin
      filtro_d = '0;
    end else if (bus.nivel_valido) begin
      filtro_d = qualifica ? filtro_q + LARG_FILTRO'(1) : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filtro_q <= '0;
    end else begin
      filtro_q <= filtro_d;
    end
  end
`else
  assign dispara_abre  = amostra_baixa;
  assign dispara_fecha = amostra_alta;
`endif

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    alarme_d = alarme_q;
    case (estado_q)
      StInicio: begin
        // Always drive a close after reset so the valve's auto path starts closed.
        estado_d = StFecha;
      end
      StFechada: begin
        if (dispara_abre) begin
          estado_d = StAbre;
        end
      end
      StAbre: begin
        cont_d   = '0;
        estado_d = StAberta;
      end
      StAberta: begin
        if (cont_q != CONT_TMAX) begin
          cont_d = cont_q + LARG_CONT'(1);
        end
        if (bus.manual || !bus.habilita) begin
          estado_d = StFecha;
        end else if (dispara_fecha) begin
          // Level-driven close beats a coincident timeout: no alarm.
          estado_d = StFecha;
        end else if (cont_q == CONT_TMAX) begin
          estado_d = StFecha;
          alarme_d = 1'b1;
        end
      end
      StFecha: begin
        estado_d = alarme_q ? StAlarme : StFechada;
      end
      StAlarme: begin
        if (bus.manual) begin
          alarme_d = 1'b0;
          estado_d = StFechada;
        end
      end
      default: begin
        estado_d = StInicio;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= StInicio;
      cont_q   <= '0;
      alarme_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      alarme_q <= alarme_d;
    end
  end

  // Moore outputs decoded from the state register.
  assign bus.abre_auto   = (estado_q == StAbre);
  assign bus.fecha_auto  = (estado_q == StFecha);
  assign bus.valvula_est = (estado_q == StAbre) || (estado_q == StAberta);
  assign bus.alarme      = alarme_q;
  assign bus.db_estado   = estado_q;

  a_parametros: assert property (@(posedge clock)
    (NIVEL_MIN < NIVEL_MAX) && (T_MIN_ABERTA < T_MAX_ABERTA) && (FILTRO_N > 0));

  a_pulsos_exclusivos: assert property (@(posedge clock) disable iff (reset)
    !(bus.abre_auto && bus.fecha_auto));

endmodule
